// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forwarding codes follow the EX operand mux input order: RF, W result, M ALU result.
package hazard_unit_pkg;

   localparam int REG_AW_DEF = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN  = 2'b00,
      ST_WAIT = 2'b01,
      ST_ERR  = 2'b10
   } state_t;

endpackage

// File: rtl/hazard_unit_forward_sel.sv
// Priority compare for one EX operand: the M-stage result beats the W-stage
// result, and register x0 is never forwarded.
module forward_sel
   import hazard_unit_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic [REG_AW-1:0] rs,
   input  logic [REG_AW-1:0] rdm,
   input  logic [REG_AW-1:0] rdw,
   input  logic              regwritem,
   input  logic              regwritew,
   output logic [1:0]        fwd
);

   logic hit_m;
   logic hit_w;

   assign hit_m = regwritem && (rdm != '0) && (rdm == rs);
   assign hit_w = regwritew && (rdw != '0) && (rdw == rs);

   always_comb begin
      fwd = FWD_RF;
      if (hit_m) begin
         fwd = FWD_MEM;
      end else if (hit_w) begin
         fwd = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller: operand forwarding selects, load-use / branch / memory-wait
// stall and flush controls, memory-wait timeout tracking and perf counters.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int REG_AW      = REG_AW_DEF,
   parameter int TIMEOUT_CYC = 64,
   parameter int CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] Rs1D,
   input  logic [REG_AW-1:0] Rs2D,
   input  logic [REG_AW-1:0] Rs1E,
   input  logic [REG_AW-1:0] Rs2E,
   input  logic [REG_AW-1:0] RdE,
   input  logic [REG_AW-1:0] RdM,
   input  logic [REG_AW-1:0] RdW,
   input  logic              LoadE,
   input  logic              RegWriteM,
   input  logic              RegWriteW,
   input  logic              PCSrcE,
   input  logic              MemReqM,
   input  logic              MemReadyM,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic              StallF,
   output logic              StallD,
   output logic              StallE,
   output logic              StallM,
   output logic              FlushD,
   output logic              FlushE,
   output logic              FlushW,
   output logic              MemErr,
   output logic [CNT_W-1:0]  StallCnt,
   output logic [CNT_W-1:0]  FlushCnt
);

   localparam int WCW = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYC - 1);

   state_t            state_reg, state_next;
   logic [WCW-1:0]    wait_cnt_reg, wait_cnt_next;
   logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
   logic [CNT_W-1:0]  flush_cnt_reg, flush_cnt_next;

   logic              err;
   logic              mem_stall;
   logic              ld_stall;
   logic              any_stall;
   logic              flush_evt;

   logic [REG_AW-1:0] rs_e [2];
   logic [1:0]        fwd  [2];

   assign rs_e[0] = Rs1E;
   assign rs_e[1] = Rs2E;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         forward_sel #(
            .REG_AW (REG_AW)
         ) u_forward_sel (
            .rs        (rs_e[gi]),
            .rdm       (RdM),
            .rdw       (RdW),
            .regwritem (RegWriteM),
            .regwritew (RegWriteW),
            .fwd       (fwd[gi])
         );
      end
   endgenerate

   assign err       = (state_reg == ST_ERR);
   assign mem_stall = MemReqM && !MemReadyM;
   assign ld_stall  = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

   // Memory wait holds E, so branch/load-use decisions are simply re-made after release.
   always_comb begin
      ForwardAE = fwd[0];
      ForwardBE = fwd[1];
      StallF    = mem_stall || ld_stall;
      StallD    = mem_stall || ld_stall;
      StallE    = mem_stall;
      StallM    = mem_stall;
      FlushD    = !mem_stall && PCSrcE;
      FlushE    = !mem_stall && (PCSrcE || ld_stall);
      FlushW    = mem_stall;
      if (err) begin
         ForwardAE = FWD_RF;
         ForwardBE = FWD_RF;
         StallF    = 1'b1;
         StallD    = 1'b1;
         StallE    = 1'b1;
         StallM    = 1'b1;
         FlushD    = 1'b0;
         FlushE    = 1'b0;
         FlushW    = 1'b0;
      end
   end

   assign MemErr   = err;
   assign StallCnt = stall_cnt_reg;
   assign FlushCnt = flush_cnt_reg;

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      case (state_reg)
         ST_RUN: begin
            if (mem_stall) begin
               state_next    = ST_WAIT;
               wait_cnt_next = WCW'(1);
            end
         end
         ST_WAIT: begin
            if (!mem_stall) begin
               state_next    = ST_RUN;
               wait_cnt_next = '0;
            end else if (wait_cnt_reg == WAIT_LAST) begin
               state_next    = ST_ERR;
            end else begin
               wait_cnt_next = wait_cnt_reg + WCW'(1);
            end
         end
         ST_ERR: begin
            state_next = ST_ERR;
         end
         default: begin
            state_next    = ST_RUN;
            wait_cnt_next = '0;
         end
      endcase
   end

   // Counters freeze in ERR and stick at all-ones instead of wrapping.
   assign any_stall = StallF || StallD || StallE || StallM;
   assign flush_evt = PCSrcE && !mem_stall && !err;

   always_comb begin
      stall_cnt_next = stall_cnt_reg;
      flush_cnt_next = flush_cnt_reg;
      if (!err && any_stall && !(&stall_cnt_reg)) begin
         stall_cnt_next = stall_cnt_reg + CNT_W'(1);
      end
      if (flush_evt && !(&flush_cnt_reg)) begin
         flush_cnt_next = flush_cnt_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_RUN;
         wait_cnt_reg  <= '0;
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         wait_cnt_reg  <= wait_cnt_next;
         stall_cnt_reg <= stall_cnt_next;
         flush_cnt_reg <= flush_cnt_next;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector table, corner-case sequences and
// a randomized run against a behavioural model.
module tb_hazard_unit;

   localparam int REG_AW  = 5;
   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 4;
   localparam int CMAX    = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic LoadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
   logic [1:0] ForwardAE, ForwardBE;
   logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
   logic [CNT_W-1:0] StallCnt, FlushCnt;

   int tests = 0;
   int fails = 0;

   hazard_unit #(.REG_AW(REG_AW), .TIMEOUT_CYC(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .LoadE(LoadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int m_consec = 0;
   int m_scnt   = 0;
   int m_fcnt   = 0;
   bit m_err    = 1'b0;

   function automatic bit ms_f();
      return MemReqM && !MemReadyM;
   endfunction

   function automatic bit ld_f();
      return LoadE && (RdE != 0) && ((RdE == Rs1D) || (RdE == Rs2D));
   endfunction

   function automatic logic [1:0] fwd_ref(input logic [REG_AW-1:0] rs);
      if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
      if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_err <= 1'b0; m_consec <= 0; m_scnt <= 0; m_fcnt <= 0;
      end else if (!m_err) begin
         if (ms_f()) begin
            m_consec <= m_consec + 1;
            if (m_consec + 1 >= TIMEOUT) m_err <= 1'b1;
         end else begin
            m_consec <= 0;
         end
         if (ms_f() || ld_f()) m_scnt <= (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
         if (PCSrcE && !ms_f()) m_fcnt <= (m_fcnt < CMAX) ? m_fcnt + 1 : CMAX;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic idle();
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
      LoadE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
   endtask

   task automatic do_reset();
      @(negedge clk); idle(); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic check_all(input string tag);
      logic [1:0] ea, eb; logic [3:0] es; logic [2:0] ef;
      bit ms, ld;
      ms = ms_f(); ld = ld_f();
      if (m_err) begin
         ea = 0; eb = 0; es = 4'hf; ef = 3'b000;
      end else begin
         ea = fwd_ref(Rs1E); eb = fwd_ref(Rs2E);
         es = {ms || ld, ms || ld, ms, ms};
         ef = {!ms && PCSrcE, !ms && (PCSrcE || ld), ms};
      end
      chk({tag, "_fwdA"}, 32'(ForwardAE), 32'(ea));
      chk({tag, "_fwdB"}, 32'(ForwardBE), 32'(eb));
      chk({tag, "_stall"}, 32'({StallF, StallD, StallE, StallM}), 32'(es));
      chk({tag, "_flush"}, 32'({FlushD, FlushE, FlushW}), 32'(ef));
      chk({tag, "_memerr"}, 32'(MemErr), 32'(m_err));
      chk({tag, "_scnt"}, 32'(StallCnt), 32'(m_scnt));
      chk({tag, "_fcnt"}, 32'(FlushCnt), 32'(m_fcnt));
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [REG_AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      logic loade, rwm, rww, pcsrc, memreq, memready;
      logic [1:0] fa, fb;
      logic [3:0] stall;   // {F,D,E,M}
      logic [2:0] flush;   // {D,E,W}
   } vec_t;

   vec_t vt [13];

   initial begin
      //        rs1d rs2d rs1e rs2e rde rdm rdw ld rwm rww pc req rdy  fa     fb     stall    flush
      vt[0]  = '{0, 0, 5, 0, 0, 5, 5, 0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 4'b0000, 3'b000};
      vt[1]  = '{0, 0, 5, 0, 0, 5, 5, 0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 4'b0000, 3'b000};
      vt[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000};
      vt[3]  = '{0, 0, 3, 9, 0, 9, 9, 0, 1, 1, 0, 0, 0, 2'b00, 2'b10, 4'b0000, 3'b000};
      vt[4]  = '{0, 0, 4, 4, 0, 4, 4, 0, 0, 1, 0, 0, 0, 2'b01, 2'b01, 4'b0000, 3'b000};
      vt[5]  = '{0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b1100, 3'b010};
      vt[6]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000};
      vt[7]  = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000};
      vt[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b110};
      vt[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 4'b1111, 3'b001};
      vt[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 4'b0000, 3'b000};
      vt[11] = '{3, 0, 0, 0, 3, 0, 0, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 4'b1100, 3'b110};
      vt[12] = '{0, 3, 0, 0, 3, 0, 0, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b1111, 3'b001};

      idle();
      // Table phase runs with reset held: state stays RUN, outputs follow inputs.
      rst = 1'b1;
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         Rs1D = vt[i].rs1d; Rs2D = vt[i].rs2d; Rs1E = vt[i].rs1e; Rs2E = vt[i].rs2e;
         RdE = vt[i].rde; RdM = vt[i].rdm; RdW = vt[i].rdw; LoadE = vt[i].loade;
         RegWriteM = vt[i].rwm; RegWriteW = vt[i].rww; PCSrcE = vt[i].pcsrc;
         MemReqM = vt[i].memreq; MemReadyM = vt[i].memready;
         #1;
         chk($sformatf("vec%0d_fwdA", i), 32'(ForwardAE), 32'(vt[i].fa));
         chk($sformatf("vec%0d_fwdB", i), 32'(ForwardBE), 32'(vt[i].fb));
         chk($sformatf("vec%0d_stall", i), 32'({StallF, StallD, StallE, StallM}), 32'(vt[i].stall));
         chk($sformatf("vec%0d_flush", i), 32'({FlushD, FlushE, FlushW}), 32'(vt[i].flush));
         $display("[TB] vec %0d fwd=%b/%b stall=%b%b%b%b flush=%b%b%b", i, ForwardAE, ForwardBE,
                  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW);
      end

      // Reset state
      @(negedge clk); idle(); #1;
      chk("reset_memerr", 32'(MemErr), 0);
      chk("reset_scnt", 32'(StallCnt), 0);
      chk("reset_fcnt", 32'(FlushCnt), 0);
      @(negedge clk); rst = 1'b0;

      // Load-use: one bubble, StallCnt +1
      do_reset();
      @(negedge clk); LoadE = 1; RdE = 7; Rs2D = 7; #1;
      chk("lduse_stallFD_flushE", 32'({StallF, StallD, FlushE}), 32'h7);
      chk("lduse_scnt_before", 32'(StallCnt), 0);
      @(negedge clk); idle(); #1;
      chk("lduse_scnt_after", 32'(StallCnt), 1);
      chk("lduse_released", 32'({StallF, StallD, FlushE}), 0);
      $display("[TB] load-use seq StallCnt=%0d", StallCnt);

      // Branch under memory wait: flush deferred until the wait drops
      do_reset();
      @(negedge clk); PCSrcE = 1; MemReqM = 1; MemReadyM = 0; #1;
      chk("br_wait_flushDE", 32'({FlushD, FlushE}), 0);
      chk("br_wait_stall", 32'({StallF, StallD, StallE, StallM}), 32'hf);
      chk("br_wait_flushW", 32'(FlushW), 1);
      @(negedge clk); MemReqM = 0; #1;
      chk("br_rel_flushDE", 32'({FlushD, FlushE}), 3);
      chk("br_rel_fcnt0", 32'(FlushCnt), 0);
      @(negedge clk); idle(); #1;
      chk("br_fcnt", 32'(FlushCnt), 1);
      $display("[TB] branch seq FlushCnt=%0d", FlushCnt);

      // Timeout: four consecutive wait cycles -> ERR, absorbing until reset
      do_reset();
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         MemReqM = 1; MemReadyM = (c >= 6);
         Rs1E = 5; RdM = 5; RegWriteM = 1; PCSrcE = (c >= 7); #1;
         chk($sformatf("to_c%0d_memerr", c), 32'(MemErr), 32'(c >= 5));
         chk($sformatf("to_c%0d_stall", c), 32'({StallF, StallD, StallE, StallM}),
             (c <= 5) ? 32'hf : 32'hf);
         if (c >= 5) begin
            chk($sformatf("to_c%0d_fwdA", c), 32'(ForwardAE), 0);
            chk($sformatf("to_c%0d_flush", c), 32'({FlushD, FlushE, FlushW}), 0);
            chk($sformatf("to_c%0d_scnt", c), 32'(StallCnt), 4);
            chk($sformatf("to_c%0d_fcnt", c), 32'(FlushCnt), 0);
         end
         $display("[TB] timeout cycle %0d MemErr=%0b StallCnt=%0d", c, MemErr, StallCnt);
      end
      @(negedge clk); rst = 1'b1; #1;
      chk("to_rst_memerr", 32'(MemErr), 0);
      @(negedge clk); rst = 1'b0; idle();

      // Asynchronous reset in the middle of a wait
      do_reset();
      @(negedge clk); MemReqM = 1; MemReadyM = 0;
      @(posedge clk); @(posedge clk); #3;
      chk("async_pre_scnt", 32'(StallCnt), 2);
      rst = 1'b1; #1;
      chk("async_memerr", 32'(MemErr), 0);
      chk("async_scnt", 32'(StallCnt), 0);
      chk("async_fcnt", 32'(FlushCnt), 0);
      chk("async_stall_follow", 32'({StallF, StallE, FlushW}), 32'h7);
      $display("[TB] async reset StallCnt=%0d MemErr=%0b", StallCnt, MemErr);
      @(negedge clk); rst = 1'b0;
      // Fresh wait after release must run the full timeout again
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk); #1;
         chk($sformatf("async_rewait%0d_memerr", c), 32'(MemErr), 0);
      end
      @(negedge clk); idle();

      // Saturation: 17 load-use stall cycles on a 4-bit counter
      do_reset();
      for (int c = 0; c < 17; c++) begin
         @(negedge clk); LoadE = 1; RdE = 2; Rs1D = 2;
      end
      @(negedge clk); idle(); #1;
      chk("sat_scnt", 32'(StallCnt), 15);
      $display("[TB] saturation StallCnt=%0d", StallCnt);

      // Randomized run against the model
      do_reset();
      begin
         int err_age = 0;
         for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rst = (err_age > 2);
            Rs1D = REG_AW'($urandom_range(0, 3)); Rs2D = REG_AW'($urandom_range(0, 3));
            Rs1E = REG_AW'($urandom_range(0, 3)); Rs2E = REG_AW'($urandom_range(0, 3));
            RdE  = REG_AW'($urandom_range(0, 3)); RdM  = REG_AW'($urandom_range(0, 3));
            RdW  = REG_AW'($urandom_range(0, 3));
            LoadE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1)); PCSrcE = ($urandom_range(0, 3) == 0);
            MemReqM = 1'($urandom_range(0, 1)); MemReadyM = ($urandom_range(0, 2) == 0);
            #1;
            check_all($sformatf("rnd%0d", n));
            err_age = m_err ? err_age + 1 : 0;
            $display("[TB] rnd %0d fwd=%b/%b stall=%b%b%b%b flush=%b%b%b err=%0b sc=%0d fc=%0d", n,
                     ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                     FlushD, FlushE, FlushW, MemErr, StallCnt, FlushCnt);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
